// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: op encoding, FSM states,
// flag bit positions and a helper that classifies the multi-cycle ops.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_MOD  = 4'd4,
    ALU_MUL  = 4'd5,
    ALU_DIV  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SHL  = 4'd8,
    ALU_SHR  = 4'd9,
    ALU_PASS = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // MUL, DIV and MOD go through the iterative engine; everything else is single-cycle.
  function automatic logic is_multi_cycle_f(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider.
// Both algorithms share the hi/lo shift registers and one iteration counter.
// After start_i the engine runs WIDTH iterations; done_o is raised during the
// cycle whose clock edge performs the last iteration, and the outputs then
// show the final (post-iteration) values so the caller can register them on
// that same edge.
//   MUL: {hi,lo} ends as the 2*WIDTH-bit product.
//   DIV: lo ends as the quotient, hi as the remainder.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_prod_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             hi_nonzero_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic             busy_q;
  logic             mul_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   trial_s;

  // One iteration: add-and-shift-right for MUL, trial-subtract-and-shift-left for DIV.
  always_comb begin
    add_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    trial_s = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (mul_q) begin
      hi_d = add_s[WIDTH:1];
      lo_d = {add_s[0], lo_q[WIDTH-1:1]};
    end else if (!trial_s[WIDTH]) begin
      hi_d = trial_s[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Load operands on start, then iterate until the counter reaches the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      mul_q  <= (op_i == ALU_MUL);
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= a_i;
      opb_q  <= b_i;
    end else if (busy_q) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= (cnt_q != LAST_CNT);
    end
  end

  assign done_o       = busy_q && (cnt_q == LAST_CNT);
  assign quo_prod_o   = lo_d;
  assign rem_o        = hi_d;
  assign hi_nonzero_o = |hi_d;

endmodule

// File: rtl/alu_secuencial.sv
// Registered, handshaked ALU. Single-cycle ops finish one cycle after accept;
// MUL/DIV/MOD use alu_iter_muldiv and finish WIDTH+1 cycles after accept.
// Result and {N,Z,C,V} flags are held stable while out_valid waits for out_ready.
// Build option: define ALU_SHIFT_AMT_EN to make SHL/SHR shift by
// b[$clog2(WIDTH)-1:0]; otherwise they shift by exactly one bit.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;
  logic [3:0]       op_q;
  logic             bzero_q;

  logic             in_ready_s;
  logic             accept_s;
  logic             start_s;

  logic [SW-1:0]    shamt_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   shr_s;
  logic [WIDTH-1:0] one_res_s;
  logic             one_c_s;
  logic             one_v_s;

  logic             eng_done_s;
  logic [WIDTH-1:0] eng_qp_s;
  logic [WIDTH-1:0] eng_rem_s;
  logic             eng_hinz_s;
  logic [WIDTH-1:0] mc_res_s;
  logic             mc_c_s;
  logic             mc_v_s;

  // N and Z always come from the final result; C and V are op-specific.
  function automatic logic [3:0] flags_f(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign start_s    = accept_s && is_multi_cycle_f(sel);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_s),
    .op_i         (sel),
    .a_i          (a),
    .b_i          (b),
    .done_o       (eng_done_s),
    .quo_prod_o   (eng_qp_s),
    .rem_o        (eng_rem_s),
    .hi_nonzero_o (eng_hinz_s)
  );

  // Single-cycle datapath evaluated straight from the request operands.
  always_comb begin
`ifdef ALU_SHIFT_AMT_EN
    shamt_s = b[SW-1:0];
`else
    shamt_s = SW'(1);
`endif
    add_s     = {1'b0, a} + {1'b0, b};
    sub_s     = {1'b0, a} - {1'b0, b};
    shl_s     = {1'b0, a} << shamt_s;
    shr_s     = {a, 1'b0} >> shamt_s;
    one_res_s = a;
    one_c_s   = 1'b0;
    one_v_s   = 1'b0;
    case (sel)
      ALU_ADD: begin
        one_res_s = add_s[WIDTH-1:0];
        one_c_s   = add_s[WIDTH];
        one_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        one_res_s = sub_s[WIDTH-1:0];
        one_c_s   = !sub_s[WIDTH];
        one_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: one_res_s = a & b;
      ALU_OR:  one_res_s = a | b;
      ALU_XOR: one_res_s = a ^ b;
      ALU_SHL: begin
        one_res_s = shl_s[WIDTH-1:0];
        one_c_s   = shl_s[WIDTH];
      end
      ALU_SHR: begin
        one_res_s = shr_s[WIDTH:1];
        one_c_s   = shr_s[0];
      end
      default: one_res_s = a;
    endcase
  end

  // Select the engine output for the latched multi-cycle op; divide by zero forces DIV to all ones.
  always_comb begin
    mc_res_s = eng_qp_s;
    mc_c_s   = 1'b0;
    mc_v_s   = 1'b0;
    case (op_q)
      ALU_MUL: begin
        mc_res_s = eng_qp_s;
        mc_c_s   = eng_hinz_s;
        mc_v_s   = eng_hinz_s;
      end
      ALU_DIV: begin
        mc_res_s = bzero_q ? {WIDTH{1'b1}} : eng_qp_s;
        mc_v_s   = bzero_q;
      end
      ALU_MOD: begin
        mc_res_s = eng_rem_s;
        mc_v_s   = bzero_q;
      end
      default: mc_res_s = eng_qp_s;
    endcase
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      op_q        <= 4'd0;
      bzero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_s) begin
            if (is_multi_cycle_f(sel)) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
              op_q        <= sel;
              bzero_q     <= (b == '0);
            end else begin
              state_q     <= DONE;
              result_q    <= one_res_s;
              flags_q     <= flags_f(one_res_s, one_c_s, one_v_s);
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (eng_done_s) begin
            state_q     <= DONE;
            result_q    <= mc_res_s;
            flags_q     <= flags_f(mc_res_s, mc_c_s, mc_v_s);
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial (WIDTH=8). Expected {result,flags}
// pairs are queued when a request is driven; a monitor pops and compares them
// on every output handshake. Feature tasks add latency/handshake checks.
module tb_alu_secuencial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
    logic [3:0] lat;
  } vec_t;

  localparam vec_t VECS [16] = '{
    '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b1001, 4'd1},
    '{4'd1,  8'h05, 8'h05, 8'h00, 4'b0110, 4'd1},
    '{4'd1,  8'h03, 8'h05, 8'hFE, 4'b1000, 4'd1},
    '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b0011, 4'd1},
    '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b0110, 4'd1},
    '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 4'd1},
    '{4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b1000, 4'd1},
    '{4'd7,  8'hAA, 8'hAA, 8'h00, 4'b0100, 4'd1},
    '{4'd15, 8'h9C, 8'h11, 8'h9C, 4'b1000, 4'd1},
    '{4'd5,  8'h10, 8'h10, 8'h00, 4'b0111, 4'd9},
    '{4'd5,  8'h0C, 8'h0B, 8'h84, 4'b1000, 4'd9},
    '{4'd5,  8'hFF, 8'hFF, 8'h01, 4'b0011, 4'd9},
    '{4'd6,  8'h64, 8'h07, 8'h0E, 4'b0000, 4'd9},
    '{4'd4,  8'h64, 8'h07, 8'h02, 4'b0000, 4'd9},
    '{4'd6,  8'h2A, 8'h00, 8'hFF, 4'b1001, 4'd9},
    '{4'd4,  8'h2A, 8'h00, 8'h2A, 4'b0001, 4'd9}
  };

`ifdef ALU_SHIFT_AMT_EN
  localparam vec_t SVECS [3] = '{
    '{4'd8, 8'h81, 8'h03, 8'h08, 4'b0000, 4'd1},
    '{4'd9, 8'h81, 8'h03, 8'h10, 4'b0000, 4'd1},
    '{4'd8, 8'h55, 8'h00, 8'h55, 4'b0000, 4'd1}
  };
`else
  localparam vec_t SVECS [3] = '{
    '{4'd8, 8'h81, 8'h03, 8'h02, 4'b0010, 4'd1},
    '{4'd9, 8'h81, 8'h03, 8'h40, 4'b0010, 4'd1},
    '{4'd8, 8'h55, 8'h00, 8'hAA, 4'b1000, 4'd1}
  };
`endif

  alu_secuencial #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int r = 0;
    int amt;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [7:0] rr;
`ifdef ALU_SHIFT_AMT_EN
    amt = uy % 8;
`else
    amt = 1;
`endif
    case (op)
      4'd0: begin r = ux + uy; c = (r > 255); v = ((sx + sy) > 127) || ((sx + sy) < -128); end
      4'd1: begin r = ux - uy; c = (ux >= uy); v = ((sx - sy) > 127) || ((sx - sy) < -128); end
      4'd2: r = ux & uy;
      4'd3: r = ux | uy;
      4'd7: r = ux ^ uy;
      4'd4: begin r = (uy == 0) ? ux : ux % uy; v = (uy == 0); end
      4'd5: begin r = ux * uy; c = (r > 255); v = c; end
      4'd6: begin r = (uy == 0) ? 255 : ux / uy; v = (uy == 0); end
      4'd8: begin r = ux << amt; c = (amt != 0) && (((ux >> (8 - amt)) & 1) == 1); end
      4'd9: begin r = ux >> amt; c = (amt != 0) && (((ux >> (amt - 1)) & 1) == 1); end
      default: r = ux;
    endcase
    rr = r[7:0];
    return {rr, rr[7], (rr == 8'h00), c, v};
  endfunction

  // Drive one request, queue its expected output, return just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv, input logic [11:0] expv);
    sel      = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    do @(negedge clk); while (!in_ready);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare each handshaken output against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_unexpected: got res=%h flags=%b, expected no output", result, flags);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({result, flags} !== e) begin
          n_errors++;
          $display("FAIL scoreboard: got res=%h flags=%b, expected res=%h flags=%b",
                   result, flags, e[11:4], e[3:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = 8'h00; b = 8'h00; sel = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, result, flags} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
      n_errors++;
      $display("FAIL reset_state: got ov=%b ir=%b res=%h flags=%b, expected ov=0 ir=1 res=00 flags=0000",
               out_valid, in_ready, result, flags);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name, input vec_t v);
    int lat;
    send(v.op, v.a, v.b, {v.r, v.f});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    n_checks++;
    if (lat !== int'(v.lat)) begin
      n_errors++;
      $display("FAIL %s_latency op=%0d: got %0d cycles, expected %0d", name, v.op, lat, v.lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops();
    for (int i = 0; i < 16; i++) run_table("ops", VECS[i]);
  endtask

  task automatic test_shift();
    for (int i = 0; i < 3; i++) run_table("shift", SVECS[i]);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'd0, 8'h12, 8'h34, {8'h46, 4'b0000});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 8'h46, 4'b0000}) begin
        n_errors++;
        $display("FAIL backpressure_hold cyc=%0d: got ov=%b ir=%b res=%h flags=%b, expected ov=1 ir=0 res=46 flags=0000",
                 i, out_valid, in_ready, result, flags);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sel = 4'd1; a = 8'h05; b = 8'h05; in_valid = 1'b1;
    exp_q.push_back({8'h00, 4'b0110});
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL no_bubble_ready: got in_ready=%b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'h00, 4'b0110}) begin
      n_errors++;
      $display("FAIL no_bubble_result: got ov=%b res=%h flags=%b, expected ov=1 res=00 flags=0110",
               out_valid, result, flags);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_div();
    int seen;
    send(4'd6, 8'h64, 8'h07, {8'h0E, 4'b0000});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({out_valid, in_ready, result, flags} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
      n_errors++;
      $display("FAIL reset_mid_div: got ov=%b ir=%b res=%h flags=%b, expected ov=0 ir=1 res=00 flags=0000",
               out_valid, in_ready, result, flags);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL reset_discard: got %0d cycles of out_valid after reset, expected 0", seen);
    end
    @(posedge clk);
    #1;
    run_table("after_reset", VECS[0]);
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [7:0] av;
      logic [7:0] bv;
      op = 4'($urandom_range(0, 15));
      av = 8'($urandom_range(0, 255));
      bv = (i % 7 == 3) ? 8'h00 : 8'($urandom_range(0, 255));
      send(op, av, bv, model(op, av, bv));
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL back_to_back_drain: got %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // Overall time limit so a stuck handshake still reaches the summary line.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got simulation still running at time limit, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    test_reset();
    test_ops();
    test_shift();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
